// File: rtl/sap1_pkg.sv
// ---------------------------------------------------------------------------
// sap1_pkg
// Shared definitions for the SAP-1 control sequencer:
//   - opcode constants as they appear in IR[7:4]
//   - bit positions inside the 12-bit control word
//     {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}, cp is the MSB
//   - the one-hot T-state encoding (bit0 = T1 ... bit5 = T6)
//   - a small helper that builds a single-bit control mask
// ---------------------------------------------------------------------------
package sap1_pkg;

    localparam int CTRL_W = 12;
    localparam int T_W    = 6;

    // Opcodes (upper nibble of the instruction register)
    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Control word bit indices
    localparam int CTRL_CP = 11;  // PC count enable
    localparam int CTRL_EP = 10;  // PC drives bus
    localparam int CTRL_LM = 9;   // MAR load
    localparam int CTRL_CE = 8;   // RAM drives bus
    localparam int CTRL_LI = 7;   // IR load
    localparam int CTRL_EI = 6;   // IR operand drives bus
    localparam int CTRL_LA = 5;   // ACC load
    localparam int CTRL_EA = 4;   // ACC drives bus
    localparam int CTRL_SU = 3;   // ALU subtract select
    localparam int CTRL_EU = 2;   // ALU drives bus
    localparam int CTRL_LB = 1;   // B register load
    localparam int CTRL_LO = 0;   // OUT register load

    localparam logic [CTRL_W-1:0] CTRL_NONE = '0;

    // Every control bit that puts a value onto the shared bus
    localparam int BUS_SRC_N = 5;
    localparam int BUS_SRC_IDX [BUS_SRC_N] = '{CTRL_EP, CTRL_CE, CTRL_EI, CTRL_EA, CTRL_EU};

    // One-hot ring states; the encoding is exported directly as t_state
    typedef enum logic [T_W-1:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    // Single-bit control mask for a given bit index
    function automatic logic [CTRL_W-1:0] ctrl_bit(input int idx);
        return CTRL_W'(1) << idx;
    endfunction

endpackage

// File: rtl/sap1_step_gen.sv
// ---------------------------------------------------------------------------
// sap1_step_gen
// Produces the one-cycle step tick that paces the SAP-1 ring counter.
//   clk_50mhz_i  board clock, rising edge
//   reset_n_i    asynchronous active-low reset
//   run_i        1 = auto stepping from the divider, 0 = manual stepping
//   step_req_i   one-cycle manual step pulse (used only while run_i = 0)
//   halt_i       suppresses the tick (already halted, or halting this edge)
//   tick_o       registered one-cycle step pulse
// Auto mode: the divider counts 0..STEP_DIV-1 and the tick follows the
// cycle in which it sits at its last value. Manual mode: the divider is
// held at 0 and the tick is step_req_i delayed by one cycle.
// ---------------------------------------------------------------------------
module sap1_step_gen #(
    parameter int STEP_DIV = 25000000,
    parameter int DIV_W    = 25
) (
    input  logic clk_50mhz_i,
    input  logic reset_n_i,
    input  logic run_i,
    input  logic step_req_i,
    input  logic halt_i,
    output logic tick_o
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick_q;
    logic             tick_d;
    logic             div_terminal;

    // The terminal count is judged on the registered divider value and not
    // gated by run_i: if run drops in the very cycle the divider sits at its
    // last value, that tick still goes out. With run low the divider is
    // forced to 0, which is never terminal because STEP_DIV >= 2.
    assign div_terminal = (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q;
        if (!run_i || div_terminal) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    // step_req_i is only honoured in manual mode, including the cycle in
    // which run_i rises.
    always_comb begin
        tick_d = div_terminal || (!run_i && step_req_i);
        if (halt_i) begin
            tick_d = 1'b0;
        end
    end

    always_ff @(posedge clk_50mhz_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/sap1_control_sequencer.sv
// ---------------------------------------------------------------------------
// sap1_control_sequencer
// SAP-1 control unit: six-state one-hot ring counter T1..T6, step pacing,
// and opcode decode into the active-high control word.
//   clk_50mhz  board clock, all state on the rising edge
//   reset_n    asynchronous active-low reset
//   run        1 = auto stepping, 0 = manual stepping via step_req
//   step_req   one-cycle manual step pulse
//   opcode     IR[7:4]
//   tick       registered one-cycle step pulse; datapath loads when high
//   t_state    one-hot ring state, bit0 = T1 ... bit5 = T6
//   ctrl       control word {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}
//   halted     sticky halt flag, cleared only by reset
// ---------------------------------------------------------------------------
module sap1_control_sequencer
    import sap1_pkg::*;
#(
    parameter int STEP_DIV = 25000000,
    parameter int DIV_W    = 25
) (
    input  logic              clk_50mhz,
    input  logic              reset_n,
    input  logic              run,
    input  logic              step_req,
    input  logic [3:0]        opcode,
    output logic              tick,
    output logic [T_W-1:0]    t_state,
    output logic [CTRL_W-1:0] ctrl,
    output logic              halted
);

    t_state_e            state_q;
    logic                halted_q;
    logic                tick_w;
    logic                halt_now;
    logic [CTRL_W-1:0]   ctrl_word;
    logic [BUS_SRC_N-1:0] bus_src;

    // HLT is recognised on the T4 step edge; the ring stays parked at T4.
    assign halt_now = tick_w && (state_q == T4) && (opcode == OP_HLT);

    // The step generator is told about a halt in the same cycle it is taken,
    // so a manual pulse queued right behind the HLT step cannot leak a tick.
    sap1_step_gen #(
        .STEP_DIV (STEP_DIV),
        .DIV_W    (DIV_W)
    ) u_step_gen (
        .clk_50mhz_i (clk_50mhz),
        .reset_n_i   (reset_n),
        .run_i       (run),
        .step_req_i  (step_req),
        .halt_i      (halted_q || halt_now),
        .tick_o      (tick_w)
    );

    // -----------------------------------------------------------------------
    // Ring counter and halt flag
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= T1;
            halted_q <= 1'b0;
        end else if (tick_w) begin
            if (halt_now) begin
                halted_q <= 1'b1;
            end else begin
                case (state_q)
                    T1:      state_q <= T2;
                    T2:      state_q <= T3;
                    T3:      state_q <= T4;
                    T4:      state_q <= T5;
                    T5:      state_q <= T6;
                    T6:      state_q <= T1;
                    default: state_q <= T1;
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Control word decode. T1..T3 form the fetch cycle and ignore the
    // opcode, since the IR only takes the new instruction at the end of T3.
    // -----------------------------------------------------------------------
    always_comb begin
        ctrl_word = CTRL_NONE;
        case (state_q)
            T1: ctrl_word = ctrl_bit(CTRL_EP) | ctrl_bit(CTRL_LM);
            T2: ctrl_word = ctrl_bit(CTRL_CP);
            T3: ctrl_word = ctrl_bit(CTRL_CE) | ctrl_bit(CTRL_LI);
            T4: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB:
                        ctrl_word = ctrl_bit(CTRL_EI) | ctrl_bit(CTRL_LM);
                    OP_OUT:
                        ctrl_word = ctrl_bit(CTRL_EA) | ctrl_bit(CTRL_LO);
                    default:
                        ctrl_word = CTRL_NONE;
                endcase
            end
            T5: begin
                case (opcode)
                    OP_LDA:
                        ctrl_word = ctrl_bit(CTRL_CE) | ctrl_bit(CTRL_LA);
                    OP_ADD, OP_SUB:
                        ctrl_word = ctrl_bit(CTRL_CE) | ctrl_bit(CTRL_LB);
                    default:
                        ctrl_word = CTRL_NONE;
                endcase
            end
            T6: begin
                case (opcode)
                    OP_ADD:
                        ctrl_word = ctrl_bit(CTRL_EU) | ctrl_bit(CTRL_LA);
                    OP_SUB:
                        ctrl_word = ctrl_bit(CTRL_EU) | ctrl_bit(CTRL_SU)
                                  | ctrl_bit(CTRL_LA);
                    default:
                        ctrl_word = CTRL_NONE;
                endcase
            end
            default: ctrl_word = CTRL_NONE;
        endcase
    end

    // Gather the bus-driving enables so the single-driver rule can be watched
    generate
        for (genvar gi = 0; gi < BUS_SRC_N; gi++) begin : g_bus_src
            assign bus_src[gi] = ctrl_word[BUS_SRC_IDX[gi]];
        end
    endgenerate

    // At most one register may drive the bus in any T-state
    a_single_bus_driver: assert property (
        @(posedge clk_50mhz) disable iff (!reset_n) $onehot0(bus_src)
    );

    // Once halted, the step tick never fires again
    a_no_tick_when_halted: assert property (
        @(posedge clk_50mhz) disable iff (!reset_n) halted_q |-> !tick_w
    );

    assign tick    = tick_w;
    assign t_state = state_q;
    assign ctrl    = ctrl_word;
    assign halted  = halted_q;

endmodule
